dual_edge_capture_fifo: RTL and testbench
=========================================

# dual_edge_capture_fifo

Parametrised successor to the single-bit dual-edge flip-flop. It samples a WIDTH-bit bus on both edges of CLK and packs each rising/falling sample pair into one 2*WIDTH word. Packed words are buffered in a DEPTH-entry FIFO and drained through a valid/ready port in the posedge domain. It sits at the boundary between DDR-style source data and the single-rate datapath.

## Interface
- WIDTH, 8, bits per edge sample
- DEPTH, 4, FIFO entries; power of two, at least 2
- CLK  input  1  sole clock; both edges are used for capture, and all control logic is on the posedge
- RST_N  input  1  asynchronous, active-low reset
- EN  input  1  capture enable, sampled at posedge
- MODE  input  2  capture mode, sampled at posedge: 00 = DDR, 01 = rising only, 10 = falling only, 11 = hold (no capture)
- D  input  WIDTH  data bus
- Q_LIVE  output  WIDTH  dual-edge follower: takes D at every CLK edge
- Q_DATA  output  2*WIDTH  FIFO head word
- Q_VALID  output  1  FIFO non-empty
- Q_READY  input  1  consumer accept
- COUNT  output  $clog2(DEPTH+1)  FIFO occupancy
- OVERFLOW  output  1  sticky flag: a word was dropped
- CLR_OVF  input  1  synchronous clear of OVERFLOW, at posedge

## Operation
- **Reset (RST_N = 0):** all registers in both edge domains clear immediately.
  - Q_LIVE, Q_DATA, COUNT, OVERFLOW: 0.
  - Q_VALID: 0.
  - Any partial pair is discarded.
- **Q_LIVE:** follows D on both edges, regardless of EN and MODE.
- **Capture cycle k:** starts at posedge k.
  - EN and MODE are latched at posedge k and govern the samples taken at posedge k and at negedge k.
- **DDR (00):**
  - lo = D at posedge k, hi = D at negedge k.
  - Word {hi, lo} is pushed at posedge k+1.
- **Rising only (01):** word {WIDTH'b0, D at posedge k} is pushed at posedge k+1.
- **Falling only (10):** word {WIDTH'b0, D at negedge k} is pushed at posedge k+1.
- **Hold (11) or EN = 0:** no push for cycle k.
- **Pop:** occurs at a posedge when Q_VALID & Q_READY.
  - Q_DATA presents the next entry after that edge.
- **Push when full, no pop that edge:** the word is dropped, the FIFO is unchanged and OVERFLOW is set.
- **Push and pop on the same edge when full:** both occur, COUNT is unchanged and there is no overflow.
- **Push and pop on the same edge when empty:** impossible, since Q_VALID = 0.
- **OVERFLOW clearing:** cleared by CLR_OVF at posedge.
  - If CLR_OVF and a new drop coincide, OVERFLOW stays 1 (set wins).
- **Pointers:** read and write pointers wrap modulo DEPTH.
  - COUNT = pushes − pops, range 0..DEPTH.

## Timing
- **Latency:** posedge k capture → Q_VALID = 1 after posedge k+1. There is no bypass of the FIFO.
- **Throughput:** one word per CLK cycle in any capture mode.
- **Negedge sample handoff:** held in a negedge register, then read by posedge logic at posedge k+1.
  - Only the negedge-to-posedge half-cycle path exists.
- **Mode or EN change at posedge k:** affects cycle k onward.
  - The word from cycle k−1 is still pushed at posedge k under the old mode.
- **Reset released mid-cycle:**
  - The first capture cycle starts at the first posedge with RST_N = 1.
  - A negedge sample taken before that posedge is discarded.
- **Q_VALID / Q_DATA:** registered; stable between posedges.
- **Q_LIVE:** changes only at CLK edges.

## Test plan
- **Reset:** assert RST_N = 0 mid-cycle with 2 entries queued → all outputs are 0 immediately. After release, MODE = 00 and EN = 1 → first word appears after 2 posedges.
- **DDR pack:** WIDTH = 8. D = 0x12 at posedge, 0x34 at negedge → Q_DATA = 0x3412 with Q_VALID = 1 after the next posedge. Q_LIVE shows 0x12 then 0x34.
- **Single-edge modes:**
  - MODE = 01 with D = 0xA5 at posedge and 0x5A at negedge → Q_DATA = 0x00A5.
  - MODE = 10 with the same stimulus → Q_DATA = 0x005A.
  - MODE = 11 → COUNT unchanged.
- **Full/overflow:** DEPTH = 4, Q_READY = 0, 5 DDR cycles → COUNT = 4, OVERFLOW = 1, the FIFO holds words 1–4. CLR_OVF pulse → OVERFLOW = 0.
- **Full with simultaneous pop:** FIFO full, Q_READY = 1, continuous DDR capture → COUNT stays 4, OVERFLOW stays 0, words are drained in order.
- **Mode switch:** MODE changes from 00 to 01 at posedge k → the word pushed at posedge k is DDR-packed, and the word pushed at posedge k+1 has a zero upper half.

Source files
------------

// File: rtl/dual_edge_capture_fifo_if.sv
// Packed-word output stream of the dual-edge capture FIFO.
// The master drives data/valid and the slave returns ready.
interface dual_edge_capture_fifo_if #(
  parameter int WIDTH = 8
) ();
  logic [2*WIDTH-1:0] q_data;
  logic               q_valid;
  logic               q_ready;

  modport master (output q_data, output q_valid, input q_ready);
  modport slave  (input q_data, input q_valid, output q_ready);
endinterface

// File: rtl/dual_edge_capture_fifo.sv
// Samples d on both clk edges, packs each rise/fall pair into a word and pushes it one posedge later.
// The words wait in a DEPTH-entry FIFO drained by valid/ready; a push into a full FIFO is dropped and flags sticky overflow.
module dual_edge_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  output logic [WIDTH-1:0]             q_live,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  input  logic                         clr_ovf,
  dual_edge_capture_fifo_if.master     q
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    MODE_DDR  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic               cap_vld;
  mode_e              mode_q;
  logic [2*WIDTH-1:0] word;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               full;
  logic               pop;
  logic               do_push;
  logic               drop;

  // Posedge sample plus the control that governs the whole capture cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q    <= '0;
      cap_vld <= 1'b0;
      mode_q  <= MODE_DDR;
    end else begin
      lo_q    <= d;
      cap_vld <= en && (mode != MODE_HOLD);
      mode_q  <= mode_e'(mode);
    end
  end

  // Only posedge logic reads hi_q, so the sole crossing is negedge-to-posedge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
    end else begin
      hi_q <= d;
    end
  end

  // While clk is high the posedge sample is newest, while low the negedge one.
  assign q_live = clk ? lo_q : hi_q;

  always_comb begin
    word = '0;
    unique case (mode_q)
      MODE_DDR:  word = {hi_q, lo_q};
      MODE_RISE: word = {{WIDTH{1'b0}}, lo_q};
      MODE_FALL: word = {{WIDTH{1'b0}}, hi_q};
      default:   word = '0;
    endcase
  end

  assign full    = (count == CW'(DEPTH));
  assign pop     = q.q_valid && q.q_ready;
  assign do_push = cap_vld && (!full || pop);
  assign drop    = cap_vld && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A fresh drop outranks a clear on the same edge.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  assign q.q_data  = mem[rd_ptr];
  assign q.q_valid = (count != '0);

endmodule

// File: tb/tb_dual_edge_capture_fifo.sv
// Directed stimulus with a queue-based scoreboard for dual_edge_capture_fifo (WIDTH=8, DEPTH=4).
module tb_dual_edge_capture_fifo;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] d;
  logic       clr_ovf;
  logic [7:0] q_live;
  logic [2:0] count;
  logic       overflow;

  dual_edge_capture_fifo_if #(.WIDTH(8)) sif ();

  dual_edge_capture_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .q_live   (q_live),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .q        (sif.master)
  );

  typedef struct {
    int          tgt;
    logic [15:0] w;
  } pend_t;

  pend_t       pend [$];
  logic [15:0] mq [$];
  logic        movf;
  int          edge_n;
  int          total;
  int          bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial edge_n = 0;
  always @(posedge clk) edge_n = edge_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One capture cycle, entered and left at negedge+1; exp is the hand-computed packed word.
  task automatic cyc(input logic e, input logic [1:0] m, input logic [7:0] dp,
                     input logic [7:0] dn, input logic [15:0] exp);
    pend_t p;
    en   = e;
    mode = m;
    d    = dp;
    @(posedge clk);
    #1;
    chk("q_live_rise", q_live, dp);
    d = dn;
    @(negedge clk);
    #1;
    chk("q_live_fall", q_live, dn);
    if (e && m != 2'b11) begin
      p.tgt = edge_n + 1;
      p.w   = exp;
      pend.push_back(p);
    end
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  // Monitor: just before each posedge, compare the DUT against the model and apply that edge's pop/push.
  initial begin : monitor
    logic        pop;
    logic        psh;
    logic        full;
    logic [15:0] w;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        chk("count", count, mq.size());
        chk("q_valid", sif.q_valid, mq.size() != 0);
        chk("overflow", overflow, movf);
        if (mq.size() != 0) chk("q_data", sif.q_data, mq[0]);
        pop  = sif.q_valid && sif.q_ready;
        full = (mq.size() == 4);
        psh  = (pend.size() != 0) && (pend[0].tgt == edge_n + 1);
        w    = 16'h0;
        if (psh) w = pend.pop_front().w;
        if (pop && mq.size() != 0) void'(mq.pop_front());
        if (psh && full && !pop) begin
          movf = 1'b1;
        end else begin
          if (psh) mq.push_back(w);
          if (clr_ovf) movf = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad = 0;
    movf = 1'b0;
    rst_n = 1'b0;
    en = 1'b0;
    mode = 2'b00;
    d = 8'h00;
    clr_ovf = 1'b0;
    sif.q_ready = 1'b0;

    #2;
    chk("rst_q_live", q_live, 0);
    chk("rst_q_data", sif.q_data, 0);
    chk("rst_q_valid", sif.q_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    #1;

    // DDR pack and first-word latency
    cyc(1'b1, 2'b00, 8'h12, 8'h34, 16'h3412);
    chk("lat_not_yet", sif.q_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", sif.q_valid, 1);
    chk("lat_data", sif.q_data, 16'h3412);
    @(negedge clk);
    #1;

    // single-edge and hold modes
    cyc(1'b1, 2'b01, 8'hA5, 8'h5A, 16'h00A5);
    cyc(1'b1, 2'b10, 8'hA5, 8'h5A, 16'h005A);
    cyc(1'b1, 2'b11, 8'hA5, 8'h5A, 16'h0000);
    idle(1);
    chk("hold_count", count, 3);
    sif.q_ready = 1'b1;
    idle(4);
    sif.q_ready = 1'b0;

    // fill to full, fifth word dropped
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] lo;
      logic [7:0] hi;
      lo = 8'(i);
      hi = 8'(8'h10 + i);
      cyc(1'b1, 2'b00, lo, hi, {hi, lo});
    end
    idle(1);
    chk("full_count", count, 4);
    chk("full_ovf", overflow, 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // full with simultaneous pop, ending with a DDR->rising mode switch
    cyc(1'b1, 2'b00, 8'h21, 8'h31, 16'h3121);
    sif.q_ready = 1'b1;
    cyc(1'b1, 2'b00, 8'h22, 8'h32, 16'h3222);
    cyc(1'b1, 2'b00, 8'h23, 8'h33, 16'h3323);
    cyc(1'b1, 2'b00, 8'h24, 8'h34, 16'h3424);
    cyc(1'b1, 2'b01, 8'h25, 8'h35, 16'h0025);
    chk("pop_push_count", count, 4);
    chk("pop_push_ovf", overflow, 0);
    for (int i = 0; i < 20 && sif.q_valid; i++) idle(1);
    chk("drained1", count, 0);

    // reset asserted mid-cycle with two entries queued
    sif.q_ready = 1'b0;
    cyc(1'b1, 2'b00, 8'h41, 8'h51, 16'h5141);
    cyc(1'b1, 2'b10, 8'h42, 8'h52, 16'h0052);
    idle(1);
    chk("pre_rst_count", count, 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    mq.delete();
    pend.delete();
    movf = 1'b0;
    #1;
    chk("mrst_q_live", q_live, 0);
    chk("mrst_q_data", sif.q_data, 0);
    chk("mrst_q_valid", sif.q_valid, 0);
    chk("mrst_count", count, 0);
    chk("mrst_overflow", overflow, 0);
    d = 8'hEE;
    en = 1'b1;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    cyc(1'b1, 2'b00, 8'h11, 8'h22, 16'h2211);
    chk("rel_not_yet", sif.q_valid, 0);
    @(posedge clk);
    #1;
    chk("rel_valid", sif.q_valid, 1);
    chk("rel_data", sif.q_data, 16'h2211);
    @(negedge clk);
    #1;
    sif.q_ready = 1'b1;
    for (int i = 0; i < 20 && sif.q_valid; i++) idle(1);
    chk("drained2", count, 0);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
